// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encodings and oversampling defaults.
package uart_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    // Receiver re-samples the start bit this many ticks after the falling edge.
    function automatic int mid_bit(input int oversample);
        return oversample / 2;
    endfunction

    localparam int MID_BIT = mid_bit(DEF_OVERSAMPLE);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_tick_gen.sv
// Programmable oversampling strobe: one registered tick every counts+1 enabled cycles.
module uart_tick_gen #(
    parameter int BITS = 10
) (
    input  logic            p_clk,
    input  logic            reset,
    input  logic [BITS-1:0] counts,
    input  logic            enable,
    output logic            tick
);

    logic [BITS-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + BITS'(1);
        tick_d = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == counts) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge p_clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_core.sv
// 8N1 UART: shared baud tick generator, transmitter with holding register, and
// a receiver with a 2-flop synchronizer and mid-bit sampling.
module uart_core
    import uart_pkg::*;
#(
    parameter int BITS       = 10,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 p_clk,
    input  logic                 reset,
    input  logic [BITS-1:0]      counts,
    input  logic                 enable,
    output logic                 tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_dv,
    input  logic                 tx_start,
    output logic                 tx,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] MID_TICK  = CW'(mid_bit(OVERSAMPLE) - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    uart_tick_gen #(.BITS(BITS)) u_tick_gen (
        .p_clk  (p_clk),
        .reset  (reset),
        .counts (counts),
        .enable (enable),
        .tick   (tick)
    );

    tx_state_e            tx_state_q;
    logic [CW-1:0]        tx_cnt_q;
    logic [BW-1:0]        tx_bit_q;
    logic [DATA_BITS-1:0] tx_hold_q, tx_shift_q;
    logic                 tx_q, tx_done_q;

    always_ff @(posedge p_clk) begin
        if (reset) begin
            tx_hold_q <= '0;
        end else if (tx_dv) begin
            tx_hold_q <= tx_data;
        end
    end

    // tx_q always carries the level of the current bit; the shift register is
    // advanced only between data bits so shift[0] is the bit on the line.
    always_ff @(posedge p_clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_shift_q <= tx_hold_q;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (tx_cnt_q == LAST_TICK) begin
                            tx_cnt_q   <= '0;
                            tx_bit_q   <= '0;
                            tx_q       <= tx_shift_q[0];
                            tx_state_q <= TX_DATA;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + CW'(1);
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_cnt_q == LAST_TICK) begin
                            tx_cnt_q <= '0;
                            if (tx_bit_q == LAST_BIT) begin
                                tx_q       <= 1'b1;
                                tx_state_q <= TX_STOP;
                            end else begin
                                tx_bit_q   <= tx_bit_q + BW'(1);
                                tx_shift_q <= tx_shift_q >> 1;
                                tx_q       <= tx_shift_q[1];
                            end
                        end else begin
                            tx_cnt_q <= tx_cnt_q + CW'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (tx_cnt_q == LAST_TICK) begin
                            tx_cnt_q   <= '0;
                            tx_done_q  <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + CW'(1);
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_done = tx_done_q;

    rx_state_e            rx_state_q;
    logic [CW-1:0]        rx_cnt_q;
    logic [BW-1:0]        rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q, rx_data_q;
    logic                 rx_meta_q, rx_sync_q, rx_done_q;

    always_ff @(posedge p_clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // After the start-bit check the tick count restarts, so every later sample
    // lands in the middle of its bit.
    always_ff @(posedge p_clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_cnt_q == MID_TICK) begin
                            rx_cnt_q <= '0;
                            rx_bit_q <= '0;
                            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + CW'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_cnt_q == LAST_TICK) begin
                            rx_cnt_q   <= '0;
                            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                            if (rx_bit_q == LAST_BIT) begin
                                rx_state_q <= RX_STOP;
                            end else begin
                                rx_bit_q <= rx_bit_q + BW'(1);
                            end
                        end else begin
                            rx_cnt_q <= rx_cnt_q + CW'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_cnt_q == LAST_TICK) begin
                            rx_cnt_q <= '0;
                            if (rx_sync_q) begin
                                rx_data_q <= rx_shift_q;
                                rx_done_q <= 1'b1;
                            end
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + CW'(1);
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign rx_done = rx_done_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: tick period table, loopback frames, rx frame
// table with framing errors, glitch rejection and reset during transmit.
module tb_uart_core;

    logic       p_clk = 1'b0;
    logic       reset;
    logic [9:0] counts;
    logic       enable;
    logic       tick;
    logic [7:0] tx_data;
    logic       tx_dv;
    logic       tx_start;
    logic       tx;
    logic       tx_done;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       loop_en;
    logic       rx_drv;

    assign rx = loop_en ? tx : rx_drv;

    uart_core dut (
        .p_clk    (p_clk),
        .reset    (reset),
        .counts   (counts),
        .enable   (enable),
        .tick     (tick),
        .tx_data  (tx_data),
        .tx_dv    (tx_dv),
        .tx_start (tx_start),
        .tx       (tx),
        .tx_done  (tx_done),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done)
    );

    always #5 p_clk = ~p_clk;

    int checks = 0;
    int failures = 0;
    int tx_done_cnt = 0;
    int rx_done_cnt = 0;

    always @(negedge p_clk) begin
        if (tx_done === 1'b1) tx_done_cnt++;
        if (rx_done === 1'b1) rx_done_cnt++;
    end

    typedef struct {
        logic [9:0] counts;
        logic       en;
        int         period;
    } tick_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         exp_done;
        logic [7:0] exp_data;
    } frame_vec_t;

    tick_vec_t  tick_tab[4];
    frame_vec_t frame_tab[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int limit, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge p_clk);
            if (tick === 1'b1) begin
                ok = 1'b1;
                t  = i;
                break;
            end
        end
    endtask

    // One bit time is 64 cycles with counts = 3. A bad stop bit stays low for
    // 48 cycles: past the receiver's mid-bit sample, short enough to read as a glitch after.
    task automatic send_frame(input logic [7:0] data, input logic stop_ok);
        rx_drv = 1'b0;
        repeat (64) @(negedge p_clk);
        for (int b = 0; b < 8; b++) begin
            rx_drv = data[b];
            repeat (64) @(negedge p_clk);
        end
        if (stop_ok) begin
            rx_drv = 1'b1;
            repeat (64) @(negedge p_clk);
        end else begin
            rx_drv = 1'b0;
            repeat (48) @(negedge p_clk);
            rx_drv = 1'b1;
        end
        repeat (128) @(negedge p_clk);
    endtask

    initial begin
        int         t1, t2, t0, td, base, rel, cnt;
        bit         ok1, ok2, hi_ok;
        logic [7:0] byte_v;
        logic       exp_bit;

        tick_tab[0] = '{10'd3,   1'b1, 4};
        tick_tab[1] = '{10'd542, 1'b1, 543};
        tick_tab[2] = '{10'd0,   1'b1, 1};
        tick_tab[3] = '{10'd3,   1'b0, 0};

        frame_tab[0] = '{8'h3C, 1'b0, 0, 8'h5A};
        frame_tab[1] = '{8'hA5, 1'b1, 1, 8'hA5};
        frame_tab[2] = '{8'h00, 1'b1, 1, 8'h00};
        frame_tab[3] = '{8'hFF, 1'b0, 0, 8'h00};
        frame_tab[4] = '{8'h81, 1'b1, 1, 8'h81};

        // Clock/reset
        reset = 1'b1; counts = 10'd3; enable = 1'b0;
        tx_data = 8'h00; tx_dv = 1'b0; tx_start = 1'b0;
        loop_en = 1'b0; rx_drv = 1'b1;
        repeat (10) @(negedge p_clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_tick", {31'd0, tick}, 32'd0);
        check("reset_tx_done", {31'd0, tx_done}, 32'd0);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        reset = 1'b0;

        // Tick period table
        for (int v = 0; v < 4; v++) begin
            enable = 1'b0;
            counts = tick_tab[v].counts;
            @(negedge p_clk);
            enable = tick_tab[v].en;
            if (tick_tab[v].en) begin
                wait_tick(2000, t1, ok1);
                wait_tick(2000, t2, ok2);
                check($sformatf("tick_seen_%0d", v), {30'd0, ok1, ok2}, 32'd3);
                check($sformatf("tick_period_%0d", v), t2, tick_tab[v].period);
                if (tick_tab[v].period > 1) begin
                    @(negedge p_clk);
                    check($sformatf("tick_width_%0d", v), {31'd0, tick}, 32'd0);
                end
            end else begin
                cnt = 0;
                repeat (100) begin
                    @(negedge p_clk);
                    if (tick !== 1'b0) cnt++;
                end
                check("tick_disabled", cnt, 0);
            end
        end

        // Loopback 0x77
        counts = 10'd3; enable = 1'b1; loop_en = 1'b1;
        repeat (5) @(negedge p_clk);
        tx_data = 8'h77; tx_dv = 1'b1;
        @(negedge p_clk);
        tx_dv = 1'b0; tx_start = 1'b1;
        base = rx_done_cnt;
        cnt = tx_done_cnt;
        t0 = -1; td = -1;
        byte_v = 8'h77;
        for (int i = 1; i <= 760; i++) begin
            @(negedge p_clk);
            if (i == 100) tx_start = 1'b0;
            if (t0 < 0 && tx === 1'b0) t0 = i;
            if (td < 0 && tx_done === 1'b1) td = i;
            rel = i - t0;
            if (t0 >= 0 && rel % 64 == 32 && rel / 64 < 10) begin
                if (rel / 64 == 0) exp_bit = 1'b0;
                else if (rel / 64 == 9) exp_bit = 1'b1;
                else exp_bit = byte_v[rel / 64 - 1];
                check($sformatf("loop_tx_bit_%0d", rel / 64), {31'd0, tx}, {31'd0, exp_bit});
            end
        end
        check("loop_start_latency", t0, 1);
        if (td < 630 || td > 650)
            check("loop_tx_done_latency", td, 640);
        else
            check("loop_tx_done_latency", {31'd0, tx_done}, 32'd0);
        repeat (200) @(negedge p_clk);
        check("loop_tx_done_count", tx_done_cnt - cnt, 1);
        check("loop_rx_done_count", rx_done_cnt - base, 1);
        check("loop_rx_data", {24'd0, rx_data}, 32'h77);
        check("loop_tx_idle", {31'd0, tx}, 32'd1);

        // Load and start in the same cycle: frame carries the previous load
        tx_data = 8'h5A; tx_dv = 1'b1;
        @(negedge p_clk);
        tx_data = 8'hC3; tx_start = 1'b1;
        @(negedge p_clk);
        tx_dv = 1'b0; tx_start = 1'b0;
        base = rx_done_cnt;
        ok1 = 1'b0;
        for (int i = 0; i < 900; i++) begin
            @(negedge p_clk);
            if (rx_done === 1'b1) begin
                ok1 = 1'b1;
                break;
            end
        end
        check("same_cycle_rx_seen", {31'd0, ok1}, 32'd1);
        check("same_cycle_rx_data", {24'd0, rx_data}, 32'h5A);
        repeat (100) @(negedge p_clk);
        loop_en = 1'b0;
        repeat (20) @(negedge p_clk);

        // Receiver frame table, including framing errors
        for (int v = 0; v < 5; v++) begin
            base = rx_done_cnt;
            send_frame(frame_tab[v].data, frame_tab[v].stop_ok);
            check($sformatf("frame_done_%0d", v), rx_done_cnt - base, frame_tab[v].exp_done);
            check($sformatf("frame_data_%0d", v), {24'd0, rx_data}, {24'd0, frame_tab[v].exp_data});
        end

        // Glitches shorter than half a bit
        base = rx_done_cnt;
        rx_drv = 1'b0;
        repeat (16) @(negedge p_clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge p_clk);
        rx_drv = 1'b0;
        repeat (24) @(negedge p_clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge p_clk);
        check("glitch_no_done", rx_done_cnt - base, 0);
        check("glitch_rx_data", {24'd0, rx_data}, 32'h81);

        // Reset in the middle of a transmitted frame
        tx_data = 8'h00; tx_dv = 1'b1;
        @(negedge p_clk);
        tx_dv = 1'b0; tx_start = 1'b1;
        @(negedge p_clk);
        tx_start = 1'b0;
        repeat (200) @(negedge p_clk);
        check("midframe_tx_low", {31'd0, tx}, 32'd0);
        cnt = tx_done_cnt;
        reset = 1'b1;
        @(negedge p_clk);
        check("midframe_reset_tx", {31'd0, tx}, 32'd1);
        check("midframe_reset_tick", {31'd0, tick}, 32'd0);
        reset = 1'b0;
        hi_ok = 1'b1;
        repeat (800) begin
            @(negedge p_clk);
            if (tx !== 1'b1) hi_ok = 1'b0;
        end
        check("midframe_tx_stays_high", {31'd0, hi_ok}, 32'd1);
        check("midframe_no_tx_done", tx_done_cnt - cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Single-clock UART core: programmable 16x-oversampling baud tick generator, 8N1 transmitter and 8N1 receiver sharing that tick.
- Sits between a parallel host interface and the serial pins.
- Loopback is done externally by tying tx to rx.

Parameters:
- BITS, 10, width of the baud divisor input and tick counter.
- DATA_BITS, 8, payload bits per frame.
- OVERSAMPLE, 16, ticks per serial bit.

Ports:
- p_clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- counts  input  BITS  baud divisor; tick period is counts+1 cycles.
- enable  input  1  baud generator enable.
- tick  output  1  one-cycle oversampling strobe.
- tx_data  input  DATA_BITS  byte to transmit.
- tx_dv  input  1  load tx_data into the holding register.
- tx_start  input  1  request transmission of the holding register.
- tx  output  1  serial out, idle high.
- tx_done  output  1  one-cycle pulse at end of stop bit.
- rx  input  1  serial in, asynchronous.
- rx_data  output  DATA_BITS  last received byte.
- rx_done  output  1  one-cycle pulse when rx_data updates.

Behaviour:
- Reset (sync, active-high, wins over everything):
  - Tick counter = 0; tick = 0; tx = 1; tx_done = 0; rx_data = 0; rx_done = 0.
  - Both FSMs go to IDLE and the holding register clears; any frame in progress is aborted.
- Baud generator:
  - When enable = 1, the counter increments each cycle.
  - When counter == counts: tick = 1 for that cycle and the counter wraps to 0.
  - When enable = 0: counter is held at 0 and tick = 0.
  - counts = 0 gives tick every cycle.
  - A counts change takes effect at the next compare.
- Transmitter:
  - tx_dv = 1 in any cycle loads tx_data into the holding register. A load during a frame does not affect the frame in flight.
  - IDLE to START when tx_start = 1; the holding register is copied to the shift register. Start is level-sensitive and accepted only in IDLE.
  - START: tx = 0 for 16 ticks.
  - DATA: DATA_BITS bits, LSB first, 16 ticks each.
  - STOP: tx = 1 for 16 ticks, then tx_done pulses for 1 cycle and the FSM returns to IDLE.
  - If tx_start is still high on return to IDLE, a new frame starts.
  - tx is registered. With enable = 0 the FSM freezes mid-frame.
- Receiver:
  - rx passes through a 2-flop synchronizer.
  - IDLE to START on synchronized rx = 0.
  - START: after 8 ticks, re-sample the line. If high, it was a glitch: return to IDLE. If low, reset the tick count and go to DATA.
  - DATA: sample every 16 ticks (mid-bit), shifting in LSB first, for DATA_BITS bits.
  - STOP: sample after 16 ticks.
    - If high: rx_data is updated and rx_done pulses for 1 cycle.
    - If low (framing error): the byte is discarded, there is no rx_done and rx_data is unchanged.
  - Either way the FSM returns to IDLE.
  - rx_data holds its value until the next good frame.
- Simultaneous events:
  - tx_dv and tx_start in the same IDLE cycle: the frame carries the old holding value. Load precedes start only across cycles.
  - Transmitter and receiver are fully independent.

Decomposition:
- Package uart_pkg holds:
  - the tx and rx state enums (IDLE, START, DATA, STOP);
  - the OVERSAMPLE and DATA_BITS defaults;
  - the mid-bit constant OVERSAMPLE/2.
- One natural sub-module: uart_tick_gen (counter plus compare).
- The TX and RX FSMs live in uart_core as separate processes.

Test Plan:
- Reset and idle:
  - Stimulus: reset = 1 for 10 cycles.
  - Response: tx = 1, tick = 0, rx_done = 0, tx_done = 0, rx_data = 0.
- Tick period:
  - Stimulus: enable = 1 with counts = 3, then counts = 542.
  - Response: tick pulses every 4 cycles for counts = 3 and every 543 cycles for counts = 542, one cycle wide. With enable = 0, no ticks.
- Loopback 0x77:
  - Stimulus: tie rx to tx, counts = 3. Pulse tx_dv with tx_data = 8'h77, then tx_start = 1 for 100 cycles, enable = 1.
  - Response on tx: low 64 cycles, then bits 1,1,1,0,1,1,1,0 (64 cycles each), then high.
  - tx_done pulses once, about 640 cycles after start.
  - rx_done pulses once with rx_data = 8'h77; no second frame.
- Framing error:
  - Stimulus: drive rx with a frame whose stop bit is 0.
  - Response: no rx_done, rx_data unchanged.
  - A following valid 0xA5 frame is received correctly.
- Glitch and reset mid-frame:
  - Stimulus: an rx low pulse shorter than 8 ticks.
  - Response: no reception.
  - Stimulus: reset asserted mid-transmit.
  - Response: tx = 1 next cycle, no tx_done.
